// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on writeback.
// An issue and a writeback to the same register in one cycle leave it busy for the new producer.
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [NREG-1:0] busy_q, busy_d;

  // Clears first, then the set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) busy_d[wr_addr[k*AW +: AW]] = 1'b0;
    if (iss_en && iss_addr != '0) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, write-to-read bypass
// and an issue/writeback busy scoreboard.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif

module regfile_mp #(
  parameter  int XLEN = `XLEN,
  parameter  int NREG = `RFREG_NUM,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [NREG-1:0][XLEN-1:0] regs;

  // Later ports are assigned last, so the highest-index writer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs <= '0;
    else begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
    end
  end

  rf_scoreboard #(.NREG(NREG), .NWR(NWR), .AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            hit;

    assign ra = rd_addr[j*AW +: AW];

    // Bypass mirrors the write priority; reset forces zero even if writes are driven.
    always_comb begin
      hit = 1'b0;
      d   = regs[ra];
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == ra) begin
          hit = 1'b1;
          d   = wr_data[k*XLEN +: XLEN];
        end
      if (ra == '0 || !rst) begin
        hit = 1'b0;
        d   = '0;
      end
    end

    assign rd_data[j*XLEN +: XLEN] = d;
    assign rd_busy[j]              = busy_vec[ra] & ~hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;

  logic                clk = 1'b0, rst = 1'b0;
  logic [NWR-1:0]      wr_en = '0;
  logic [NWR*AW-1:0]   wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic [NREG-1:0]     busy_vec;

  int n_tests = 0, n_fail = 0;

  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
  endtask

  // Expected read for port j: newest same-cycle writer, else stored value; x0 is always 0.
  task automatic model_read(input int j, output logic [XLEN-1:0] d, output logic b);
    int a;
    a = int'(rd_addr[j*AW +: AW]);
    d = m_reg[a];
    b = m_busy[a];
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) begin
        d = wr_data[k*XLEN +: XLEN];
        b = 0;
      end
    if (a == 0) begin d = '0; b = 0; end
  endtask

  task automatic model_clock();
    int a;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) begin
        a = int'(wr_addr[k*AW +: AW]);
        if (a != 0) m_reg[a] = wr_data[k*XLEN +: XLEN];
        m_busy[a] = 0;
      end
    if (iss_en && iss_addr != 0) m_busy[int'(iss_addr)] = 1;
  endtask

  function automatic logic [NREG-1:0] model_busy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Called just after a negedge with inputs set: checks reads, clocks, checks scoreboard.
  task automatic run_cycle(input string tag);
    logic [XLEN-1:0] d;
    logic b;
    #1;
    for (int j = 0; j < NRD; j++) begin
      model_read(j, d, b);
      chk({tag, "_rd_data"}, 64'(rd_data[j*XLEN +: XLEN]), 64'(d));
      chk({tag, "_rd_busy"}, 64'(rd_busy[j]), 64'(b));
    end
    @(posedge clk);
    model_clock();
    #1;
    chk({tag, "_busy_vec"}, 64'(busy_vec), 64'(model_busy_vec()));
    @(negedge clk);
  endtask

  task automatic clr();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [XLEN-1:0] d);
    wr_en[k] = 1'b1; wr_addr[k*AW +: AW] = AW'(a); wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int a);
    for (int j = 0; j < NRD; j++) rd_addr[j*AW +: AW] = AW'(a);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_rd_data", 64'(rd_data), 64'(0));
    chk("reset_busy_vec", 64'(busy_vec), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Basic write then read on both ports
    clr(); set_wr(0, 5, 32'hDEADBEEF); run_cycle("wr_x5");
    clr(); set_rd(5); #1;
    chk("x5_port0", 64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);
    chk("x5_port1", 64'(rd_data[XLEN +: XLEN]), 64'hDEADBEEF);
    run_cycle("rd_x5");

    // x0 ignores writes and issues
    clr(); set_wr(0, 0, 32'h1234); iss_en = 1'b1; iss_addr = '0; set_rd(0); #1;
    chk("x0_bypass", 64'(rd_data[0 +: XLEN]), 64'h0);
    run_cycle("x0");
    chk("x0_busy", 64'(busy_vec[0]), 64'h0);
    clr(); set_rd(0); run_cycle("x0_after");

    // Same-register write conflict: port 1 wins
    clr(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(7); #1;
    chk("x7_bypass", 64'(rd_data[0 +: XLEN]), 64'h22);
    run_cycle("x7_conflict");
    clr(); set_rd(7); #1;
    chk("x7_next", 64'(rd_data[XLEN +: XLEN]), 64'h22);
    run_cycle("x7_rd");

    // Issue x9, idle 3 cycles, then writeback with bypass
    clr(); iss_en = 1'b1; iss_addr = 5'd9; run_cycle("x9_issue");
    for (int i = 0; i < 3; i++) begin
      clr(); set_rd(9); #1;
      chk("x9_idle_busy", 64'(rd_busy[0]), 64'h1);
      run_cycle("x9_idle");
    end
    clr(); set_wr(0, 9, 32'hA5); set_rd(9); #1;
    chk("x9_wb_data", 64'(rd_data[0 +: XLEN]), 64'hA5);
    chk("x9_wb_busy", 64'(rd_busy[0]), 64'h0);
    run_cycle("x9_wb");
    chk("x9_cleared", 64'(busy_vec[9]), 64'h0);

    // Set/clear race on x3
    clr(); iss_en = 1'b1; iss_addr = 5'd3; run_cycle("x3_issue");
    clr(); iss_en = 1'b1; iss_addr = 5'd3; set_wr(1, 3, 32'h77); run_cycle("x3_race");
    chk("x3_busy", 64'(busy_vec[3]), 64'h1);
    clr(); set_rd(3); #1;
    chk("x3_data", 64'(rd_data[0 +: XLEN]), 64'h77);
    run_cycle("x3_rd");

    // Randomized traffic, addresses sometimes narrowed to provoke collisions
    for (int c = 0; c < 400; c++) begin
      bit narrow;
      clr();
      narrow = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < NWR; k++) begin
        wr_en[k] = ($urandom_range(0, 2) != 0);
        wr_addr[k*AW +: AW] = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREG-1));
        wr_data[k*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRD; j++)
        rd_addr[j*AW +: AW] = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREG-1));
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, NREG-1));
      run_cycle("rand");
    end

    // Load x1..x31, mark some busy, then assert reset between edges
    for (int r = 1; r < NREG; r += 2) begin
      clr(); set_wr(0, r, $urandom | 32'h1);
      if (r + 1 < NREG) set_wr(1, r + 1, $urandom | 32'h1);
      iss_en = 1'b1; iss_addr = AW'((r * 7) % NREG);
      run_cycle("load");
    end
    clr(); iss_en = 1'b1; iss_addr = 5'd20; run_cycle("load_iss");
    chk("pre_reset_busy", 64'(busy_vec != '0), 64'h1);
    set_wr(0, 12, 32'hCAFE); iss_en = 1'b1; iss_addr = 5'd12;
    #2 rst = 1'b0;
    #1 chk("async_busy_vec", 64'(busy_vec), 64'h0);
    for (int a = 0; a < NREG; a++) begin
      rd_addr[0 +: AW] = AW'(a); rd_addr[AW +: AW] = AW'(NREG - 1 - a);
      #1;
      chk("async_rd_data", 64'(rd_data), 64'h0);
      chk("async_rd_busy", 64'(rd_busy), 64'h0);
    end
    @(posedge clk); #1;
    chk("reset_hold_busy", 64'(busy_vec), 64'h0);
    @(negedge clk);
    clr(); rst = 1'b1; model_clear();
    for (int c = 0; c < 20; c++) begin
      clr();
      set_rd($urandom_range(0, NREG-1));
      rd_addr[AW +: AW] = AW'($urandom_range(0, NREG-1));
      if (c % 2 == 0) set_wr(c % NWR, $urandom_range(1, NREG-1), $urandom);
      run_cycle("post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, the register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, the number of architectural registers; it SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter NRD, default 2, the number of read ports.
REQ-004 SHALL have parameter NWR, default 2, the number of write ports.
REQ-005 SHALL have derived localparam AW = clog2(NREG), the address width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port wr_en, input, NWR bits: per-port write enable.
REQ-009 SHALL have port wr_addr, input, NWR*AW bits: per-port write address; port k occupies slice [k*AW +: AW].
REQ-010 SHALL have port wr_data, input, NWR*XLEN bits: per-port write data, sliced as for wr_addr.
REQ-011 SHALL have port rd_addr, input, NRD*AW bits: per-port read address.
REQ-012 SHALL have port rd_data, output, NRD*XLEN bits: per-port read data.
REQ-013 SHALL have port rd_busy, output, NRD bits: the addressed register awaits a pending write.
REQ-014 SHALL have port iss_en, input, 1 bit: issue strobe that marks iss_addr busy.
REQ-015 SHALL have port iss_addr, input, AW bits: destination register being issued.
REQ-016 SHALL have port busy_vec, output, NREG bits: the registered scoreboard state.

Function
REQ-017 SHALL write wr_data[k] into register wr_addr[k] on the rising clk edge when wr_en[k]=1 and wr_addr[k]!=0.
REQ-018 SHALL let the highest-index port win when two or more enabled ports write the same register in one cycle.
REQ-019 SHALL return 0 on rd_data for address 0, ignore all writes to register 0, and never report register 0 busy.
REQ-020 SHALL make reads combinational (zero latency).
REQ-021 SHALL bypass a same-cycle write: when an enabled, nonzero wr_addr[k] equals rd_addr[j], rd_data[j] SHALL equal the winning port's wr_data in that cycle.
REQ-022 SHALL set busy[iss_addr] on the rising edge when iss_en=1 and iss_addr!=0.
REQ-023 SHALL clear busy[r] on the rising edge when any enabled write port targets r.
REQ-024 SHALL let set win when an issue and a write target the same register in the same cycle, so busy stays 1 for the new producer.
REQ-025 SHALL drive rd_busy[j] = busy[rd_addr[j]] AND NOT (same-cycle bypass hit on rd_addr[j]).
REQ-026 SHALL drive busy_vec directly from the scoreboard flops.

Reset
REQ-027 SHALL, while rst=0, clear every register to 0 and every busy bit to 0 asynchronously, independent of clk.
REQ-028 SHALL, while rst=0, drive rd_data to 0 for every address and rd_busy and busy_vec to 0; writes and issues are ignored.
REQ-029 SHALL abandon any in-flight write or issue when reset asserts mid-operation, and SHALL act on the first rising edge after rst deasserts.

Structure
REQ-030 SHALL take XLEN and NREG defaults from the shared Define.v constants (`XLEN, `RFREG_NUM, `RFIDX_WIDTH); no new package.
REQ-031 SHALL hold the scoreboard in one sub-module, rf_scoreboard, with inputs iss_en, iss_addr, wr_en and wr_addr and output busy_vec.
REQ-032 SHALL contain no simulation-only display or debug ports.

Verification
REQ-033 SHALL cover basic write/read: write x5=0xDEADBEEF on port 0, next cycle read x5 on both ports -> 0xDEADBEEF on both.
REQ-034 SHALL cover x0: write x0=0x1234 with iss_addr=0 and iss_en=1 -> rd_data for x0 is 0 and busy_vec[0]=0.
REQ-035 SHALL cover the write conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> same-cycle bypass read 0x22, and next-cycle read 0x22.
REQ-036 SHALL cover bypass plus busy: issue x9, then 3 cycles later write x9=0xA5 while reading x9 -> in the idle cycles rd_busy=1; in the write cycle rd_data=0xA5 and rd_busy=0; next cycle busy_vec[9]=0.
REQ-037 SHALL cover the set/clear race: x3 busy, then issue x3 and write x3=0x77 in one cycle -> next cycle busy_vec[3]=1 and x3 reads 0x77.
REQ-038 SHALL cover async reset: load x1..x31 and set several busy bits, then pulse rst low between clock edges -> all reads are 0 and busy_vec=0 immediately, before any clk edge.
